dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the core's dmem port (address_dmem/data/wren -> q_dmem).
//   Serves a word-addressed synchronous data RAM plus a small MMIO window (cycle counter,
//   LED register, down-timer, status), and flags accesses outside both regions.
//   Sits in Wrapper between the processor's dmem outputs and the board I/O.
// PARAMETERS
//   ADDR_WIDTH  12            RAM word-address bits; RAM occupies 0 .. 2**ADDR_WIDTH-1
//   MMIO_BASE   32'h0000_8000 word address of MMIO register 0; window is 4 words
// PORTS
//   clock        in   1   master clock; all state updates on rising edge
//   reset        in   1   asynchronous, active-low reset
//   address_dmem in   32  word address from the core's XM stage
//   data         in   32  store data
//   wren         in   1   store enable for the current address
//   q_dmem       out  32  registered read data
//   led_out      out  16  LED register contents
//   fault        out  1   sticky illegal-access flag
//   fault_addr   out  32  address of the first illegal access since last clear
// BEHAVIOUR
//   Reset (reset=0, async): q_dmem=0, led_out=0, CYCLE=0, TIMER=0, fault=0, fault_addr=0.
//     RAM contents are not reset. While reset=0, wren is ignored.
//   Decode: RAM if address_dmem < 2**ADDR_WIDTH; MMIO if MMIO_BASE <= addr < MMIO_BASE+4;
//     otherwise illegal.
//   Read latency 1: q_dmem at edge N+1 reflects the address present before edge N+1; it holds
//     until the next edge. Every cycle is a read; there is no read strobe.
//   Read-before-write: a store and a read of the same word on one edge return the OLD value.
//   Store: when wren=1 at the edge, RAM word or writable MMIO register takes data.
//   MMIO map (offset from MMIO_BASE):
//     0 CYCLE  RO  free-running 32-bit, +1 per edge, wraps FFFF_FFFF->0; read returns pre-increment value
//     1 LED    RW  bits[15:0] drive led_out; read returns {16'b0, LED}
//     2 TIMER  RW  store loads value; otherwise decrements by 1 per edge while nonzero, stops at 0;
//                  store wins over decrement on the same edge
//     3 STATUS R/W1C  bit0 = (TIMER==0), bit1 = fault; store with data[1]=1 clears fault;
//                  other bits read 0 and ignore stores
//   Illegal access (read or store): read returns 0, store discarded. If fault=0, set fault
//     and capture fault_addr; if fault=1, fault_addr unchanged (first-fault capture).
//   New fault and STATUS clear on the same edge: impossible (STATUS is legal); a clear followed
//     by an illegal access on the next edge re-sets fault with the new address.
// CONFIGURATION
//   DMEM_MMIO_EN defined: MMIO window as above.
//   DMEM_MMIO_EN undefined: no MMIO registers; window addresses decode as illegal;
//     led_out tied 0; only RAM and fault logic remain.
// STRUCTURE
//   Shared package dmem_pkg: MMIO offsets (CYCLE/LED/TIMER/STATUS), STATUS bit indices,
//     MMIO_WINDOW=4, address-decode region enum (RAM/MMIO/ILLEGAL).
//   Sub-module dmem_ram: single-port synchronous RAM, 2**ADDR_WIDTH x 32, read-before-write,
//     registered output; responder muxes its output with MMIO/zero using a registered region tag.
// TESTING
//   Store 32'hDEAD_BEEF @5, then read @5 next cycle -> q_dmem=DEAD_BEEF one edge after address.
//   Store 32'h1 @7 while reading @7 on same edge (prior value 0) -> q_dmem=0, next read -> 1.
//   Store 32'h3 to TIMER -> STATUS bit0=0 for 3 edges, reads 1 after 3rd; store 5 mid-count -> restarts at 5.
//   Read @32'h0001_0000 then @32'h0002_0000 -> both return 0, fault=1, fault_addr=0001_0000;
//     store 2 to STATUS -> fault=0; access 0002_0000 -> fault_addr=0002_0000.
//   Store 32'hABCD_1234 to LED -> led_out=16'h1234, LED read =0000_1234; pulse reset low mid-run
//     -> led_out, CYCLE, q_dmem, fault all 0 immediately (async), RAM @5 still DEAD_BEEF.
//   DMEM_MMIO_EN undefined: read MMIO_BASE -> q_dmem=0, fault=1, fault_addr=MMIO_BASE.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO offsets, STATUS bit indices and address-region tags for dmem_responder
package dmem_pkg;
    localparam int MMIO_WINDOW = 4;
    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_LED    = 2'd1;
    localparam logic [1:0] OFF_TIMER  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;
    localparam int STATUS_TIMER_ZERO = 0;
    localparam int STATUS_FAULT      = 1;
    typedef enum logic [1:0] {REGION_RAM, REGION_MMIO, REGION_ILLEGAL} region_t;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous word RAM, read-before-write, registered output
module dmem_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  we,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clock) begin
        rdata <= mem[addr];
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: dmem RAM + MMIO (CYCLE/LED/TIMER/STATUS, enabled by DMEM_MMIO_EN) with first-fault capture
import dmem_pkg::*;
module dmem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_8000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [15:0] led_out,
    output logic        fault,
    output logic [31:0] fault_addr
);
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif
    region_t     region, region_q;
    logic        in_ram, in_mmio, clear;
    logic [31:0] mmio_off, mmio_rd, mmio_q, ram_q;
    assign in_ram   = (address_dmem >> ADDR_WIDTH) == '0;
    assign mmio_off = address_dmem - MMIO_BASE;
    assign in_mmio  = mmio_off < 32'(MMIO_WINDOW);
    assign region   = in_ram ? REGION_RAM : (MMIO_EN && in_mmio) ? REGION_MMIO : REGION_ILLEGAL;
    dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clock (clock),
        .addr  (address_dmem[ADDR_WIDTH-1:0]),
        .wdata (data),
        .we    (reset && wren && region == REGION_RAM),
        .rdata (ram_q)
    );
`ifdef DMEM_MMIO_EN
    logic [31:0] cycle, timer, status;
    logic [15:0] led;
    logic [1:0]  off;
    logic        mmio_we;
    assign off     = mmio_off[1:0];
    assign mmio_we = wren && region == REGION_MMIO;
    assign clear   = mmio_we && off == OFF_STATUS && data[STATUS_FAULT];
    assign led_out = led;
    always_comb begin
        status = '0;
        status[STATUS_TIMER_ZERO] = timer == '0;
        status[STATUS_FAULT] = fault;
    end
    assign mmio_rd = off == OFF_CYCLE ? cycle : off == OFF_LED ? {16'b0, led} : off == OFF_TIMER ? timer : status;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle <= '0;
            led   <= '0;
            timer <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (mmio_we && off == OFF_LED) led <= data[15:0];
            timer <= (mmio_we && off == OFF_TIMER) ? data : timer != '0 ? timer - 32'd1 : timer;
        end
    end
`else
    assign clear   = 1'b0;
    assign led_out = '0;
    assign mmio_rd = '0;
`endif
    // Output mux keyed by the region tag registered alongside the RAM read.
    assign q_dmem = region_q == REGION_RAM ? ram_q : region_q == REGION_MMIO ? mmio_q : '0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            region_q   <= REGION_ILLEGAL;
            mmio_q     <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            region_q <= region;
            mmio_q   <= mmio_rd;
            if (clear) fault <= 1'b0;
            else if (region == REGION_ILLEGAL && !fault) begin
                fault      <= 1'b1;
                fault_addr <= address_dmem;
            end
        end
    end
endmodule
